// File: rtl/tt_sel_seq_pkg.sv
// tt_sel_seq_pkg: shared definitions for the design-select sequencer.
//   ADDR_W_DEF / PH_DEF : default address width and cycles per pad phase
//   state_e             : sequencer state encoding
//   is_timed()          : true for states that last a full pad phase
package tt_sel_seq_pkg;

    localparam int unsigned ADDR_W_DEF = 10;
    localparam int unsigned PH_DEF     = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DIS    = 3'd1,
        ST_RST    = 3'd2,
        ST_REL    = 3'd3,
        ST_INC_HI = 3'd4,
        ST_INC_LO = 3'd5,
        ST_ENA    = 3'd6
    } state_e;

    function automatic logic is_timed(state_e s);
        return (s inside {ST_DIS, ST_RST, ST_REL, ST_INC_HI, ST_INC_LO});
    endfunction

endpackage

// File: rtl/tt_sel_seq_if.sv
// tt_sel_seq_if: request/status/pad bundle of the design-select sequencer.
//   master : requester side (drives req_valid, req_addr, abort)
//   slave  : sequencer side (drives req_ready, busy, done, pad controls, cur_addr)
interface tt_sel_seq_if
    import tt_sel_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
);
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              abort;
    logic              busy;
    logic              done;
    logic              sel_rst_n;
    logic              sel_inc;
    logic              ena;
    logic [ADDR_W-1:0] cur_addr;

    modport master (
        output req_valid, req_addr, abort,
        input  req_ready, busy, done, sel_rst_n, sel_inc, ena, cur_addr
    );

    modport slave (
        input  req_valid, req_addr, abort,
        output req_ready, busy, done, sel_rst_n, sel_inc, ena, cur_addr
    );
endinterface

// File: rtl/tt_sel_phase_timer.sv
// tt_sel_phase_timer: phase down-counter for the sequencer.
//   clk, rst_n : clock, async active-low reset
//   load       : restart a phase of PH cycles
//   expired_c  : high in the last cycle of the phase (and while idle at zero)
module tt_sel_phase_timer
    import tt_sel_seq_pkg::*;
#(
    parameter int unsigned PH = PH_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expired_c
);
    localparam int unsigned CNT_W = $clog2(PH) + 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load PH-1 so the phase spans exactly PH cycles ending on the zero count.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(PH - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_c = (cnt_q == '0);

endmodule

// File: rtl/tt_sel_seq.sv
// tt_sel_seq: drives the select-counter pads (reset / increment / enable)
// to bring a design address onto cur_addr, incrementally when possible.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of tt_sel_seq_if (request, abort, status, pads)
module tt_sel_seq
    import tt_sel_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned PH     = PH_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    tt_sel_seq_if.slave  bus
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic              sel_valid_q, sel_valid_d;
    logic              ena_q, ena_d;
    logic              done_q, done_d;
    logic              sel_inc_q, sel_inc_d;
    logic              sel_rst_n_q, sel_rst_n_d;

    logic              req_ready_c;
    logic              busy_c;
    logic              phase_done_c;
    logic              timer_load_c;
    logic [ADDR_W-1:0] cur_inc_c;

    assign req_ready_c  = (state_q == ST_IDLE) && !bus.abort;
    assign busy_c       = (state_q != ST_IDLE);
    assign cur_inc_c    = cur_addr_q + ADDR_W'(1);
    // Restart the phase on every entry into a timed state.
    assign timer_load_c = (state_d != state_q) && is_timed(state_d);

    tt_sel_phase_timer #(.PH(PH)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (timer_load_c),
        .expired_c (phase_done_c)
    );

    // State register (plus target/address datapath and registered pad outputs).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tgt_q       <= '0;
            cur_addr_q  <= '0;
            sel_valid_q <= 1'b0;
            ena_q       <= 1'b0;
            done_q      <= 1'b0;
            sel_inc_q   <= 1'b0;
            sel_rst_n_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            cur_addr_q  <= cur_addr_d;
            sel_valid_q <= sel_valid_d;
            ena_q       <= ena_d;
            done_q      <= done_d;
            sel_inc_q   <= sel_inc_d;
            sel_rst_n_q <= sel_rst_n_d;
        end
    end

    // Next-state: abort overrides everything outside IDLE.
    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        cur_addr_d = cur_addr_q;
        if ((state_q != ST_IDLE) && bus.abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_ready_c && bus.req_valid) begin
                        state_d = ST_DIS;
                        tgt_d   = bus.req_addr;
                    end
                end
                ST_DIS: begin
                    if (phase_done_c) begin
                        // Counting up from a known position avoids the reset phases.
                        if (sel_valid_q && (tgt_q >= cur_addr_q)) begin
                            state_d = (tgt_q == cur_addr_q) ? ST_ENA : ST_INC_HI;
                        end else begin
                            state_d    = ST_RST;
                            cur_addr_d = '0;
                        end
                    end
                end
                ST_RST: begin
                    if (phase_done_c) state_d = ST_REL;
                end
                ST_REL: begin
                    if (phase_done_c) state_d = (tgt_q == '0) ? ST_ENA : ST_INC_HI;
                end
                ST_INC_HI: begin
                    if (phase_done_c) state_d = ST_INC_LO;
                end
                ST_INC_LO: begin
                    // The falling edge of sel_inc is what advances the external counter.
                    if (phase_done_c) begin
                        cur_addr_d = cur_inc_c;
                        state_d    = (cur_inc_c == tgt_q) ? ST_ENA : ST_INC_HI;
                    end
                end
                ST_ENA:  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output decode from the next state so the pads come straight from flops.
    always_comb begin
        ena_d       = 1'b0;
        done_d      = (state_d == ST_ENA);
        sel_inc_d   = (state_d == ST_INC_HI);
        sel_rst_n_d = (state_d != ST_RST);
        sel_valid_d = sel_valid_q;

        if (state_d == ST_ENA) begin
            ena_d = 1'b1;
        end else if ((state_d == ST_IDLE) && !bus.abort &&
                     ((state_q == ST_IDLE) || (state_q == ST_ENA))) begin
            ena_d = ena_q;
        end

        if (bus.abort) begin
            sel_valid_d = 1'b0;
        end else if (state_q == ST_ENA) begin
            sel_valid_d = 1'b1;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.busy      = busy_c;
    assign bus.done      = done_q;
    assign bus.sel_rst_n = sel_rst_n_q;
    assign bus.sel_inc   = sel_inc_q;
    assign bus.ena       = ena_q;
    assign bus.cur_addr  = cur_addr_q;

endmodule

// File: tb/tb_tt_sel_seq.sv
// tb_tt_sel_seq: table-driven selection runs with a scoreboard of expected
// latency / pulse counts / final address, plus abort and reset sequences.
module tb_tt_sel_seq;
    import tt_sel_seq_pkg::*;

    localparam int unsigned AW = ADDR_W_DEF;
    localparam int unsigned PH = 2;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    tt_sel_seq_if #(.ADDR_W(AW)) bus ();

    tt_sel_seq #(.ADDR_W(AW), .PH(PH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int unsigned lat;
        int unsigned incs;
        int unsigned rsts;
        int unsigned cur;
    } exp_t;

    typedef struct {
        int unsigned tgt;
        exp_t        e;
        bit          noise;
    } vec_t;

    exp_t        exp_q[$];
    vec_t        vecs[6];
    int unsigned n_checks = 0;
    int unsigned n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one accepted request and push its expected outcome.
    task automatic issue(input int unsigned tgt, input exp_t e);
        @(negedge clk);
        check("req_ready_before_req", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_addr  = AW'(tgt);
        exp_q.push_back(e);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    // Follow one sequence until done, then compare against the scoreboard.
    task automatic monitor(input string tag, input bit noise);
        int unsigned cnt   = 0;
        int unsigned incs  = 0;
        int unsigned rsts  = 0;
        int unsigned run_i = 0;
        int unsigned run_r = 0;
        int unsigned bad_w = 0;
        logic        p_inc  = 1'b0;
        logic        p_rstn = 1'b1;
        bit          seen   = 1'b0;
        exp_t        e;
        while (!seen && cnt < 300) begin
            @(negedge clk);
            cnt++;
            if (bus.sel_inc) begin
                if (!p_inc) incs++;
                run_i++;
            end else begin
                if (p_inc && run_i != PH) bad_w++;
                run_i = 0;
            end
            if (!bus.sel_rst_n) begin
                if (p_rstn) rsts++;
                run_r++;
            end else begin
                if (!p_rstn && run_r != PH) bad_w++;
                run_r = 0;
            end
            p_inc  = bus.sel_inc;
            p_rstn = bus.sel_rst_n;
            if (bus.done) seen = 1'b1;
            if (noise) begin
                bus.req_valid = !bus.done;
                bus.req_addr  = AW'(cnt + 17);
            end
        end
        if (exp_q.size() == 0) begin
            check({tag, ".scoreboard_empty"}, 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check({tag, ".done_seen"},   32'(seen),            32'd1);
        check({tag, ".latency"},     cnt,                  e.lat);
        check({tag, ".inc_pulses"},  incs,                 e.incs);
        check({tag, ".rst_windows"}, rsts,                 e.rsts);
        check({tag, ".phase_width"}, bad_w,                32'd0);
        check({tag, ".cur_addr"},    32'(bus.cur_addr),    e.cur);
        @(negedge clk);
        check({tag, ".done_one_cycle"}, 32'(bus.done), 32'd0);
        check({tag, ".ena_held"},       32'(bus.ena),  32'd1);
        check({tag, ".idle_after"},     32'(bus.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.abort     = 1'b0;

        vecs[0] = '{tgt: 3, e: '{lat: 19, incs: 3, rsts: 1, cur: 3}, noise: 1'b0};
        vecs[1] = '{tgt: 5, e: '{lat: 11, incs: 2, rsts: 0, cur: 5}, noise: 1'b1};
        vecs[2] = '{tgt: 2, e: '{lat: 15, incs: 2, rsts: 1, cur: 2}, noise: 1'b0};
        vecs[3] = '{tgt: 0, e: '{lat:  7, incs: 0, rsts: 1, cur: 0}, noise: 1'b0};
        vecs[4] = '{tgt: 0, e: '{lat:  3, incs: 0, rsts: 0, cur: 0}, noise: 1'b1};
        vecs[5] = '{tgt: 4, e: '{lat: 19, incs: 4, rsts: 0, cur: 4}, noise: 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.sel_rst_n", 32'(bus.sel_rst_n), 32'd1);
        check("reset.sel_inc",   32'(bus.sel_inc),   32'd0);
        check("reset.ena",       32'(bus.ena),       32'd0);
        check("reset.done",      32'(bus.done),      32'd0);
        check("reset.cur_addr",  32'(bus.cur_addr),  32'd0);
        check("reset.busy",      32'(bus.busy),      32'd0);
        check("reset.req_ready", 32'(bus.req_ready), 32'd1);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            issue(vecs[i].tgt, vecs[i].e);
            monitor($sformatf("vec%0d", i), vecs[i].noise);
        end

        // Abort during the second increment-high phase (incremental 4 -> 7).
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = AW'(7);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        begin
            int unsigned rises = 0;
            int unsigned cyc   = 0;
            logic        p     = 1'b0;
            ok = 1'b0;
            while (!ok && cyc < 100) begin
                @(negedge clk);
                cyc++;
                if (bus.done) check("abort.early_done", 32'd1, 32'd0);
                if (bus.sel_inc && !p) rises++;
                p = bus.sel_inc;
                if (rises == 2) ok = 1'b1;
            end
        end
        check("abort.reached_inc_hi2", 32'(ok), 32'd1);
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        check("abort.busy",      32'(bus.busy),      32'd0);
        check("abort.ena",       32'(bus.ena),       32'd0);
        check("abort.sel_inc",   32'(bus.sel_inc),   32'd0);
        check("abort.sel_rst_n", 32'(bus.sel_rst_n), 32'd1);
        check("abort.done",      32'(bus.done),      32'd0);
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort.no_done_after", 32'(bus.done), 32'd0);
        issue(1, '{lat: 11, incs: 1, rsts: 1, cur: 1});
        monitor("after_abort", 1'b0);

        // Abort together with a request in IDLE: request dropped, ena and sel_valid cleared.
        @(negedge clk);
        bus.abort     = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = AW'(3);
        #1 check("idle_abort.req_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;
        check("idle_abort.busy", 32'(bus.busy), 32'd0);
        check("idle_abort.ena",  32'(bus.ena),  32'd0);
        @(negedge clk);
        bus.abort     = 1'b0;
        bus.req_valid = 1'b0;
        check("idle_abort.still_idle", 32'(bus.busy),     32'd0);
        check("idle_abort.cur_addr",   32'(bus.cur_addr), 32'd1);
        // sel_valid was cleared, so tgt==cur_addr still runs the full sequence.
        issue(1, '{lat: 11, incs: 1, rsts: 1, cur: 1});
        monitor("after_idle_abort", 1'b0);

        // Asynchronous reset while sel_inc is high.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = AW'(2);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        begin
            int unsigned cyc = 0;
            ok = 1'b0;
            while (!ok && cyc < 100) begin
                @(negedge clk);
                cyc++;
                if (bus.sel_inc) ok = 1'b1;
            end
        end
        check("rst_mid.reached_inc_hi", 32'(ok), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid.sel_inc",   32'(bus.sel_inc),   32'd0);
        check("rst_mid.sel_rst_n", 32'(bus.sel_rst_n), 32'd1);
        check("rst_mid.ena",       32'(bus.ena),       32'd0);
        check("rst_mid.done",      32'(bus.done),      32'd0);
        check("rst_mid.busy",      32'(bus.busy),      32'd0);
        check("rst_mid.cur_addr",  32'(bus.cur_addr),  32'd0);
        check("rst_mid.req_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        issue(1, '{lat: 11, incs: 1, rsts: 1, cur: 1});
        monitor("after_reset", 1'b0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
